// File: rtl/i2c_slave_regfile_if.sv
// Bus bundle between the I2C target and its register file.
// Holds the raw I2C lines, the open-drain SDA enable and the regfile port.
// slave  : the I2C target (drives SDA enable and the regfile strobes).
// master : the environment (bus lines and regfile read data).
interface i2c_slave_regfile_if #(
    parameter int REG_AW = 8
);
    logic              i2c_scl;
    logic              i2c_sda;
    logic              i2c_sda_oe;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr_en;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              addr_err;

    modport slave (
        input  i2c_scl, i2c_sda, reg_rdata,
        output i2c_sda_oe, reg_addr, reg_wdata, reg_wr_en, busy, addr_err
    );

    modport master (
        output i2c_scl, i2c_sda, reg_rdata,
        input  i2c_sda_oe, reg_addr, reg_wdata, reg_wr_en, busy, addr_err
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target for the OTP controller register file.
// Oversamples SCL/SDA on clk, decodes START / device address / register
// address / data / STOP and reads or writes the register file with
// auto-increment. SDA is only ever pulled low (open-drain enable).
// Optional build macro: I2C_GLITCH_FILTER_EN adds a 3-sample majority
// filter after the synchronizers (2 clk extra latency, rejects 1-clk pulses).
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h0A,
    parameter int         NUM_REGS = 128,
    parameter int         REG_AW   = 8
) (
    input  logic                clk,
    input  logic                rst,
    i2c_slave_regfile_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR_S, DEV_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_f, sda_f;
    logic              scl_prev_q, sda_prev_q;
    state_t            state_q;
    logic [3:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [REG_AW-1:0] ptr_q;
    logic              rw_q;
    logic              master_nack_q;
    logic              inc_pend_q;
    logic              sda_oe_q;
    logic              wr_en_q;
    logic [7:0]        wdata_q;
    logic              addr_err_q;

    // Two-flop synchronizers for the asynchronous bus lines
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.i2c_scl};
            sda_sync_q <= {sda_sync_q[0], bus.i2c_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    // Three-sample history feeding the majority vote
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= '0;
            sda_hist_q <= '0;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    assign scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                   (scl_hist_q[1] & scl_hist_q[2]);
    assign sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                   (sda_hist_q[1] & sda_hist_q[2]);
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // Previous filtered values for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_q <= 1'b0;
            sda_prev_q <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    logic [REG_AW-1:0] ptr_inc;

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    // SCL must be high on both samples so a simultaneous SCL/SDA change
    // (e.g. lines settling after reset) is never taken as START/STOP.
    assign start_det = sda_prev_q & ~sda_f & scl_f & scl_prev_q;
    assign stop_det  = ~sda_prev_q & sda_f & scl_f & scl_prev_q;
    assign ptr_inc   = (ptr_q == REG_AW'(NUM_REGS - 1)) ? '0 : ptr_q + REG_AW'(1);

    // Protocol FSM with registered bus and regfile outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            ptr_q         <= '0;
            rw_q          <= 1'b0;
            master_nack_q <= 1'b0;
            inc_pend_q    <= 1'b0;
            sda_oe_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            wdata_q       <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            addr_err_q <= 1'b0;
            inc_pend_q <= 1'b0;
            // Write pointer advances the clock after the write strobe
            if (inc_pend_q)
                ptr_q <= ptr_inc;

            if (start_det) begin
                state_q   <= DEV_ADDR_S;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    DEV_ADDR_S, REG_ADDR, WR_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            if (state_q == DEV_ADDR_S) begin
                                if (shift_q[7:1] == DEV_ADDR) begin
                                    rw_q     <= shift_q[0];
                                    sda_oe_q <= 1'b1;
                                    state_q  <= DEV_ACK;
                                end else begin
                                    state_q  <= WAIT_STOP;
                                end
                            end else if (state_q == REG_ADDR) begin
                                if (int'(shift_q) < NUM_REGS) begin
                                    ptr_q    <= REG_AW'(shift_q);
                                    sda_oe_q <= 1'b1;
                                    state_q  <= REG_ACK;
                                end else begin
                                    addr_err_q <= 1'b1;
                                    state_q    <= WAIT_STOP;
                                end
                            end else begin
                                wr_en_q    <= 1'b1;
                                wdata_q    <= shift_q;
                                inc_pend_q <= 1'b1;
                                sda_oe_q   <= 1'b1;
                                state_q    <= WR_ACK;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (rw_q) begin
                                shift_q  <= bus.reg_rdata;
                                sda_oe_q <= ~bus.reg_rdata[7];
                                state_q  <= RD_DATA;
                            end else begin
                                shift_q  <= '0;
                                sda_oe_q <= 1'b0;
                                state_q  <= REG_ADDR;
                            end
                        end
                    end
                    REG_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                            sda_oe_q  <= 1'b0;
                            state_q   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= RD_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        // Pointer moves past every transmitted byte, so the
                        // next byte's data is already on reg_rdata at SCL fall.
                        if (scl_rise) begin
                            master_nack_q <= sda_f;
                            ptr_q         <= ptr_inc;
                        end else if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (!master_nack_q) begin
                                shift_q  <= bus.reg_rdata;
                                sda_oe_q <= ~bus.reg_rdata[7];
                                state_q  <= RD_DATA;
                            end else begin
                                state_q  <= WAIT_STOP;
                            end
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.i2c_sda_oe = sda_oe_q;
    assign bus.reg_addr   = ptr_q;
    assign bus.reg_wdata  = wdata_q;
    assign bus.reg_wr_en  = wr_en_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.busy       = (state_q != IDLE) && (state_q != WAIT_STOP);

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: bit-banged I2C master, regfile model,
// and a write-strobe scoreboard fed with hand-computed expected writes.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int Q = 8;  // clocks per SCL quarter period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       scl_m;
    logic       m_oe;
    logic       pre_we;
    logic [6:0] pre_addr;
    logic [7:0] pre_data;
    logic [7:0] regs [0:127];

    int vectors     = 0;
    int miscompares = 0;
    int oe_count    = 0;
    int err_count   = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_wr_q[$];

    i2c_slave_regfile_if #(.REG_AW(8)) bus ();

    assign bus.i2c_scl   = scl_m;
    assign bus.i2c_sda   = ~(m_oe | bus.i2c_sda_oe);
    assign bus.reg_rdata = regs[bus.reg_addr[6:0]];

    i2c_slave_regfile #(.DEV_ADDR(7'h0A), .NUM_REGS(128), .REG_AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file model: preload port from the bench, write port from the DUT
    always @(posedge clk) begin
        if (pre_we)
            regs[pre_addr] <= pre_data;
        else if (bus.reg_wr_en)
            regs[bus.reg_addr[6:0]] <= bus.reg_wdata;
    end

    // Monitor: scoreboard on write strobes, activity counters
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.i2c_sda_oe) oe_count++;
        if (bus.addr_err) err_count++;
        if (bus.reg_wr_en) begin
            vectors++;
            if (exp_wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got addr=%02h data=%02h, required no write",
                         bus.reg_addr, bus.reg_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                if (bus.reg_addr !== e.a || bus.reg_wdata !== e.d) begin
                    miscompares++;
                    $display("FAIL wr_strobe: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             bus.reg_addr, bus.reg_wdata, e.a, e.d);
                end else begin
                    $display("ok   wr_strobe addr=%02h data=%02h", bus.reg_addr, bus.reg_wdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        exp_wr_q.push_back({a, d});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        wait_clk(1);
        pre_we   = 1'b0;
    endtask

    task automatic i2c_start();
        m_oe = 1'b0;  wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        m_oe = 1'b1;  wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1;  wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        m_oe = 1'b0;  wait_clk(Q);
    endtask

    task automatic bus_bit(input logic drive_low, output logic seen);
        m_oe = drive_low; wait_clk(Q);
        scl_m = 1'b1;     wait_clk(Q);
        seen = bus.i2c_sda;
        wait_clk(Q);
        scl_m = 1'b0;     wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(~b[i], s);
        bus_bit(1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b0, s);
            d[i] = s;
        end
        bus_bit(master_ack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;

        rst = 1'b1; scl_m = 1'b1; m_oe = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        wait_clk(5);
        check("reset_sda_oe", bus.i2c_sda_oe, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_reg_addr", bus.reg_addr, 0);
        check("reset_wr_en", bus.reg_wr_en, 0);
        rst = 1'b0;
        wait_clk(10);

        // Write 0x12 <- FF, 0x13 <- 00
        i2c_start();
        check("wr_busy_after_start", bus.busy, 1);
        write_byte(8'h14, ack); check("wr_dev_ack", ack, 1);
        write_byte(8'h12, ack); check("wr_reg_ack", ack, 1);
        exp_wr(8'h12, 8'hFF);
        write_byte(8'hFF, ack); check("wr_d0_ack", ack, 1);
        exp_wr(8'h13, 8'h00);
        write_byte(8'h00, ack); check("wr_d1_ack", ack, 1);
        i2c_stop();
        check("wr_busy_after_stop", bus.busy, 0);
        check("wr_ptr_after", bus.reg_addr, 8'h14);

        // Wrong device address 0x0B
        oe_count = 0;
        i2c_start();
        write_byte(8'h16, ack); check("bad_dev_ack", ack, 0);
        check("bad_dev_busy", bus.busy, 0);
        write_byte(8'h55, ack);
        check("bad_dev_sda_pulls", oe_count, 0);
        i2c_stop();
        check("bad_dev_busy_after", bus.busy, 0);

        // Read 0x12/0x13 via repeated START
        preload(7'h12, 8'hA5);
        preload(7'h13, 8'h3C);
        i2c_start();
        write_byte(8'h14, ack); check("rd_dev_w_ack", ack, 1);
        write_byte(8'h12, ack); check("rd_reg_ack", ack, 1);
        i2c_start();
        write_byte(8'h15, ack); check("rd_dev_r_ack", ack, 1);
        read_byte(1'b1, d); check("rd_byte0", d, 8'hA5);
        read_byte(1'b0, d); check("rd_byte1", d, 8'h3C);
        i2c_stop();
        check("rd_ptr_after", bus.reg_addr, 8'h14);

        // Out-of-range register address
        err_count = 0;
        i2c_start();
        write_byte(8'h14, ack); check("err_dev_ack", ack, 1);
        write_byte(8'h90, ack); check("err_reg_nack", ack, 0);
        i2c_stop();
        check("err_pulses", err_count, 1);
        check("err_ptr_unchanged", bus.reg_addr, 8'h14);

        // Pointer wrap, then STOP mid-byte
        i2c_start();
        write_byte(8'h14, ack);
        write_byte(8'h7F, ack); check("wrap_reg_ack", ack, 1);
        exp_wr(8'h7F, 8'h11);
        write_byte(8'h11, ack); check("wrap_d0_ack", ack, 1);
        exp_wr(8'h00, 8'h22);
        write_byte(8'h22, ack); check("wrap_d1_ack", ack, 1);
        bus_bit(1'b1, s); bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b0, s);
        i2c_stop();
        check("partial_busy", bus.busy, 0);
        check("wrap_ptr_after", bus.reg_addr, 8'h01);
        check("wrap_pending_writes", exp_wr_q.size(), 0);

        // 1-clk SCL glitch at the start of a data byte (SDA low)
        i2c_start();
        write_byte(8'h14, ack);
        write_byte(8'h20, ack); check("glitch_reg_ack", ack, 1);
        m_oe = 1'b1;  wait_clk(Q);
        scl_m = 1'b1; wait_clk(1);
        scl_m = 1'b0; wait_clk(Q);
`ifdef I2C_GLITCH_FILTER_EN
        exp_wr(8'h20, 8'hFF);
`else
        exp_wr(8'h20, 8'h7F);
`endif
        write_byte(8'hFF, ack);
        i2c_stop();
        check("glitch_pending_writes", exp_wr_q.size(), 0);

        // Reset in the middle of a read byte
        preload(7'h06, 8'h00);
        i2c_start();
        write_byte(8'h14, ack);
        write_byte(8'h05, ack);
        exp_wr(8'h05, 8'h00);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h15, ack); check("rst_dev_r_ack", ack, 1);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
        check("pre_rst_sda_oe", bus.i2c_sda_oe, 1);
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        wait_clk(1);
        check("rst_sda_oe", bus.i2c_sda_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_en", bus.reg_wr_en, 0);
        check("rst_ptr", bus.reg_addr, 0);
        rst = 1'b0;
        m_oe = 1'b0;  wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        check("post_rst_busy", bus.busy, 0);
        check("final_pending_writes", exp_wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
